wb_trace_fifo: RTL and testbench

- Consumes the CPU top's write-back trace stream: debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum and debug_wb_rf_wdata.
- Each qualifying register-file write is stamped with a sequence number and buffered in a FIFO.
- A downstream trace-compare or host-dump agent drains the FIFO over a valid/ready port.
- Sits between the CPU top and the trace checker, so that checker back-pressure never stalls the CPU.

---
 rtl/wb_trace_fifo.sv | 195 +++++++++++++++++++
 tb/tb_wb_trace_fifo.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_trace_fifo.sv
//-----------------------------------------------------------------------------
// wb_trace_fifo
//
// Purpose:
//   Buffers the CPU write-back trace stream so a slow trace checker or host
//   dump agent can never stall the CPU. Every qualifying register-file write
//   (capture enabled, at least one byte enable set, destination not r0) is
//   stamped with a 16-bit sequence number and pushed into a DEPTH-entry FIFO.
//   The consumer drains the FIFO over a valid/ready port. When the FIFO is
//   full and nothing is popped, the capture is dropped. The sequence number
//   still advances, so the consumer sees a gap, and the sticky overflow flag
//   is set.
//
// Parameters:
//   DEPTH  FIFO entries, power of two, minimum 2
//   AW     pointer index width, equal to log2(DEPTH)
//
// Ports:
//   clk                 clock, all state updates on the rising edge
//   resetn              asynchronous active-low reset
//   capture_en          1 = capture qualifying write-back events
//   clr                 synchronous flush: empties the FIFO, clears overflow,
//                       zeroes the sequence counter (wins over push and pop)
//   debug_wb_pc         write-back PC
//   debug_wb_rf_wen     write-back byte enables
//   debug_wb_rf_wnum    destination register number
//   debug_wb_rf_wdata   write-back data
//   pc_lo, pc_hi        (TRACE_PC_WINDOW_EN only) inclusive unsigned PC window
//   trace_valid         head entry available
//   trace_ready         consumer accepts the head entry
//   trace_pc/wen/wnum/wdata/seq   head entry fields
//   fifo_count          occupancy, 0..DEPTH
//   overflow            sticky, set when a capture is dropped
//
// Optional feature (compile-time macro TRACE_PC_WINDOW_EN):
//   When defined, the ports pc_lo and pc_hi are added, and an event must
//   also satisfy pc_lo <= debug_wb_pc <= pc_hi. Out-of-window writes neither
//   push nor advance the sequence counter. If pc_hi < pc_lo, nothing is
//   captured. When the macro is not defined, these ports do not exist.
//
// Entry layout (89 bits): {seq[15:0], pc[31:0], wen[3:0], wnum[4:0], wdata[31:0]}
//-----------------------------------------------------------------------------
module wb_trace_fifo #(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          capture_en,
   input  logic          clr,
   input  logic [31:0]   debug_wb_pc,
   input  logic [3:0]    debug_wb_rf_wen,
   input  logic [4:0]    debug_wb_rf_wnum,
   input  logic [31:0]   debug_wb_rf_wdata,
`ifdef TRACE_PC_WINDOW_EN
   input  logic [31:0]   pc_lo,
   input  logic [31:0]   pc_hi,
`endif
   output logic          trace_valid,
   input  logic          trace_ready,
   output logic [31:0]   trace_pc,
   output logic [3:0]    trace_wen,
   output logic [4:0]    trace_wnum,
   output logic [31:0]   trace_wdata,
   output logic [15:0]   trace_seq,
   output logic [AW:0]   fifo_count,
   output logic          overflow
);

   localparam int SEQ_W   = 16;
   localparam int ENTRY_W = SEQ_W + 32 + 4 + 5 + 32;

   // Pack one trace record into the storage word layout.
   function automatic logic [ENTRY_W-1:0] pack_entry(
      input logic [SEQ_W-1:0] seq,
      input logic [31:0]      pc,
      input logic [3:0]       wen,
      input logic [4:0]       wnum,
      input logic [31:0]      wdata
   );
      pack_entry = {seq, pc, wen, wnum, wdata};
   endfunction

   // Storage and control state
   logic [ENTRY_W-1:0] mem_r [DEPTH];
   logic [AW:0]        wr_ptr_r;
   logic [AW:0]        rd_ptr_r;
   logic [AW:0]        count_r;
   logic [SEQ_W-1:0]   seq_r;
   logic               valid_r;
   logic               overflow_r;

   // Combinational decode
   logic               in_window_s;
   logic               event_s;
   logic               pop_s;
   logic               full_s;
   logic               push_s;
   logic               drop_s;
   logic [AW:0]        wr_ptr_nxt_s;
   logic [AW:0]        rd_ptr_nxt_s;
   logic [SEQ_W-1:0]   seq_nxt_s;
   logic               overflow_nxt_s;
   logic [ENTRY_W-1:0] wr_entry_s;
   logic [ENTRY_W-1:0] head_s;

   // PC window qualification; without the feature every PC is in the window.
   always_comb begin
      in_window_s = 1'b1;
`ifdef TRACE_PC_WINDOW_EN
      if ((debug_wb_pc >= pc_lo) && (debug_wb_pc <= pc_hi)) begin
         in_window_s = 1'b1;
      end else begin
         in_window_s = 1'b0;
      end
`endif
   end

   // Event qualification and push/pop/drop decisions.
   always_comb begin
      event_s = capture_en & (|debug_wb_rf_wen) &
                (debug_wb_rf_wnum != 5'd0) & in_window_s;
      pop_s   = valid_r & trace_ready;
      // Equal index bits with differing wrap bits mean the FIFO is full.
      full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) &
                (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
      // A pop in the same cycle frees the slot that a full FIFO needs.
      push_s  = event_s & (~full_s | pop_s);
      drop_s  = event_s & full_s & ~pop_s;
   end

   // Next-state values for the pointers, the sequence counter and overflow.
   always_comb begin
      wr_ptr_nxt_s   = wr_ptr_r + {{AW{1'b0}}, push_s};
      rd_ptr_nxt_s   = rd_ptr_r + {{AW{1'b0}}, pop_s};
      // Dropped events still consume a number so the consumer can see the gap.
      seq_nxt_s      = seq_r + {{(SEQ_W-1){1'b0}}, event_s};
      overflow_nxt_s = overflow_r | drop_s;
      wr_entry_s     = pack_entry(seq_r, debug_wb_pc, debug_wb_rf_wen,
                                  debug_wb_rf_wnum, debug_wb_rf_wdata);
   end

   // Control state: pointers, occupancy, valid, sequence counter, overflow.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr_r   <= {(AW+1){1'b0}};
         rd_ptr_r   <= {(AW+1){1'b0}};
         count_r    <= {(AW+1){1'b0}};
         valid_r    <= 1'b0;
         seq_r      <= {SEQ_W{1'b0}};
         overflow_r <= 1'b0;
      end else if (clr) begin
         // The flush takes priority: an event in this cycle is neither
         // stored nor numbered.
         wr_ptr_r   <= {(AW+1){1'b0}};
         rd_ptr_r   <= {(AW+1){1'b0}};
         count_r    <= {(AW+1){1'b0}};
         valid_r    <= 1'b0;
         seq_r      <= {SEQ_W{1'b0}};
         overflow_r <= 1'b0;
      end else begin
         wr_ptr_r   <= wr_ptr_nxt_s;
         rd_ptr_r   <= rd_ptr_nxt_s;
         // Occupancy and valid are registered copies of the pointer
         // difference, so these outputs come straight from flops.
         count_r    <= wr_ptr_nxt_s - rd_ptr_nxt_s;
         valid_r    <= (wr_ptr_nxt_s != rd_ptr_nxt_s);
         seq_r      <= seq_nxt_s;
         overflow_r <= overflow_nxt_s;
      end
   end

   // Entry storage. It is reset so the head outputs read zero out of reset;
   // clr only moves the pointers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= {ENTRY_W{1'b0}};
         end
      end else if (!clr && push_s) begin
         mem_r[wr_ptr_r[AW-1:0]] <= wr_entry_s;
      end
   end

   // The head is read directly from storage at the read pointer. There is no
   // fall-through path, so a new entry appears one cycle after its push, and
   // the head is stable while the consumer stalls.
   assign head_s = mem_r[rd_ptr_r[AW-1:0]];

   assign {trace_seq, trace_pc, trace_wen, trace_wnum, trace_wdata} = head_s;
   assign trace_valid = valid_r;
   assign fifo_count  = count_r;
   assign overflow    = overflow_r;

endmodule

// File: tb/tb_wb_trace_fifo.sv
//-----------------------------------------------------------------------------
// tb_wb_trace_fifo
//
// Directed bench for wb_trace_fifo. A queue-based reference model tracks the
// expected FIFO contents, sequence counter and overflow flag. One compare
// process checks the DUT against this model on every cycle. Literal
// expectations at key points pin down the model itself.
//-----------------------------------------------------------------------------
module tb_wb_trace_fifo;

   localparam int DEPTH = 16;
   localparam int AW    = 4;

   typedef struct packed {
      logic [15:0] seq;
      logic [31:0] pc;
      logic [3:0]  wen;
      logic [4:0]  wnum;
      logic [31:0] wdata;
   } ent_t;

   logic          clk = 1'b0;
   logic          resetn = 1'b0;
   logic          capture_en = 1'b0;
   logic          clr = 1'b0;
   logic [31:0]   debug_wb_pc = 32'd0;
   logic [3:0]    debug_wb_rf_wen = 4'd0;
   logic [4:0]    debug_wb_rf_wnum = 5'd0;
   logic [31:0]   debug_wb_rf_wdata = 32'd0;
   logic          trace_valid;
   logic          trace_ready = 1'b0;
   logic [31:0]   trace_pc;
   logic [3:0]    trace_wen;
   logic [4:0]    trace_wnum;
   logic [31:0]   trace_wdata;
   logic [15:0]   trace_seq;
   logic [AW:0]   fifo_count;
   logic          overflow;
`ifdef TRACE_PC_WINDOW_EN
   logic [31:0]   pc_lo = 32'h0000_0000;
   logic [31:0]   pc_hi = 32'hFFFF_FFFF;
`endif

   wb_trace_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk               (clk),
      .resetn            (resetn),
      .capture_en        (capture_en),
      .clr               (clr),
      .debug_wb_pc       (debug_wb_pc),
      .debug_wb_rf_wen   (debug_wb_rf_wen),
      .debug_wb_rf_wnum  (debug_wb_rf_wnum),
      .debug_wb_rf_wdata (debug_wb_rf_wdata),
`ifdef TRACE_PC_WINDOW_EN
      .pc_lo             (pc_lo),
      .pc_hi             (pc_hi),
`endif
      .trace_valid       (trace_valid),
      .trace_ready       (trace_ready),
      .trace_pc          (trace_pc),
      .trace_wen         (trace_wen),
      .trace_wnum        (trace_wnum),
      .trace_wdata       (trace_wdata),
      .trace_seq         (trace_seq),
      .fifo_count        (fifo_count),
      .overflow          (overflow)
   );

   always #5 clk = ~clk;

   // Reference model state
   ent_t        q[$];
   logic [15:0] m_seq = 16'd0;
   logic        m_ovf = 1'b0;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic model_clear();
      q.delete();
      m_seq = 16'd0;
      m_ovf = 1'b0;
   endtask

   // Advance the model by one clock edge using the inputs currently driven.
   task automatic model_step();
      bit   ev;
      bit   pop;
      bit   acc;
      ent_t e;
      if (!resetn || clr) begin
         model_clear();
         return;
      end
      ev = capture_en && (debug_wb_rf_wen != 4'd0) && (debug_wb_rf_wnum != 5'd0);
`ifdef TRACE_PC_WINDOW_EN
      ev = ev && (debug_wb_pc >= pc_lo) && (debug_wb_pc <= pc_hi);
`endif
      pop = (q.size() != 0) && trace_ready;
      acc = ev && ((q.size() < DEPTH) || pop);
      e.seq   = m_seq;
      e.pc    = debug_wb_pc;
      e.wen   = debug_wb_rf_wen;
      e.wnum  = debug_wb_rf_wnum;
      e.wdata = debug_wb_rf_wdata;
      if (ev && !acc) m_ovf = 1'b1;
      if (ev) m_seq = m_seq + 16'd1;
      if (pop) void'(q.pop_front());
      if (acc) q.push_back(e);
   endtask

   // Per-cycle comparison of the DUT against the model, sampled after the edge.
   always @(posedge clk) begin
      #2;
      chk("valid", {63'd0, trace_valid}, {63'd0, (q.size() != 0)});
      chk("count", {59'd0, fifo_count}, 64'(q.size()));
      chk("overflow", {63'd0, overflow}, {63'd0, m_ovf});
      if (q.size() != 0) begin
         chk("head_seq",   {48'd0, trace_seq},   {48'd0, q[0].seq});
         chk("head_pc",    {32'd0, trace_pc},    {32'd0, q[0].pc});
         chk("head_wen",   {60'd0, trace_wen},   {60'd0, q[0].wen});
         chk("head_wnum",  {59'd0, trace_wnum},  {59'd0, q[0].wnum});
         chk("head_wdata", {32'd0, trace_wdata}, {32'd0, q[0].wdata});
      end
   end

   // Drive one cycle of inputs (called at a falling edge), step the model,
   // and return at the next falling edge.
   task automatic cyc(input logic ce, input logic [3:0] wen, input logic [4:0] wnum,
                      input logic [31:0] pc, input logic [31:0] wd,
                      input logic rdy, input logic c);
      capture_en        = ce;
      debug_wb_rf_wen   = wen;
      debug_wb_rf_wnum  = wnum;
      debug_wb_pc       = pc;
      debug_wb_rf_wdata = wd;
      trace_ready       = rdy;
      clr               = c;
      model_step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle(input logic rdy);
      cyc(1'b0, 4'd0, 5'd0, 32'd0, 32'd0, rdy, 1'b0);
   endtask

   task automatic ev(input int i, input logic rdy);
      cyc(1'b1, 4'hF, 5'((i % 31) + 1), 32'h0000_1000 + 32'(i * 4),
          32'(i) * 32'h0101_0101 ^ 32'hA5A5_A5A5, rdy, 1'b0);
   endtask

   initial begin
      // Reset state
      model_clear();
      @(negedge clk);
      @(negedge clk);
      chk("rst_valid", {63'd0, trace_valid}, 64'd0);
      chk("rst_count", {59'd0, fifo_count}, 64'd0);
      chk("rst_ovf",   {63'd0, overflow}, 64'd0);
      chk("rst_pc",    {32'd0, trace_pc}, 64'd0);
      chk("rst_seq",   {48'd0, trace_seq}, 64'd0);
      resetn = 1'b1;

      // Three back-to-back writes with the consumer always ready
      cyc(1'b1, 4'hF, 5'd1, 32'hBFC0_0000, 32'h1111_1111, 1'b1, 1'b0);
      chk("t1_valid0", {63'd0, trace_valid}, 64'd1);
      chk("t1_seq0",   {48'd0, trace_seq}, 64'd0);
      chk("t1_pc0",    {32'd0, trace_pc}, 64'hBFC0_0000);
      cyc(1'b1, 4'hF, 5'd2, 32'hBFC0_0004, 32'h2222_2222, 1'b1, 1'b0);
      chk("t1_seq1",   {48'd0, trace_seq}, 64'd1);
      chk("t1_wnum1",  {59'd0, trace_wnum}, 64'd2);
      cyc(1'b1, 4'hF, 5'd3, 32'hBFC0_0008, 32'h3333_3333, 1'b1, 1'b0);
      chk("t1_seq2",   {48'd0, trace_seq}, 64'd2);
      chk("t1_data2",  {32'd0, trace_wdata}, 64'h3333_3333);
      idle(1'b1);
      chk("t1_count",  {59'd0, fifo_count}, 64'd0);

      // Writes to r0 and with no byte enables are ignored; seq continues at 3
      cyc(1'b1, 4'hF, 5'd0, 32'hBFC0_000C, 32'hDEAD_BEEF, 1'b0, 1'b0);
      cyc(1'b1, 4'h0, 5'd5, 32'hBFC0_0010, 32'hDEAD_BEEF, 1'b0, 1'b0);
      chk("t2_count",  {59'd0, fifo_count}, 64'd0);
      cyc(1'b1, 4'h3, 5'd7, 32'hBFC0_0014, 32'h0000_ABCD, 1'b0, 1'b0);
      chk("t2_seq",    {48'd0, trace_seq}, 64'd3);
      chk("t2_wen",    {60'd0, trace_wen}, 64'h3);
      idle(1'b1);
      // capture_en low freezes seq
      cyc(1'b0, 4'hF, 5'd7, 32'hBFC0_0018, 32'h1, 1'b0, 1'b0);
      chk("t2_ce_count", {59'd0, fifo_count}, 64'd0);
      cyc(1'b1, 4'hF, 5'd8, 32'hBFC0_001C, 32'h2, 1'b1, 1'b0);
      chk("t2_ce_seq", {48'd0, trace_seq}, 64'd4);
      idle(1'b1);

      // Fill past capacity with the consumer stalled, then drain
      cyc(1'b0, 4'd0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b1);
      for (int i = 0; i < 16; i++) ev(i, 1'b0);
      chk("t3_full_count", {59'd0, fifo_count}, 64'd16);
      chk("t3_full_ovf",   {63'd0, overflow}, 64'd0);
      ev(16, 1'b0);
      chk("t3_ovf",        {63'd0, overflow}, 64'd1);
      chk("t3_count",      {59'd0, fifo_count}, 64'd16);
      for (int i = 0; i < 16; i++) begin
         chk("t3_drain_seq", {48'd0, trace_seq}, 64'(i));
         idle(1'b1);
      end
      chk("t3_empty", {59'd0, fifo_count}, 64'd0);

      // A push into a full FIFO with a simultaneous pop is accepted
      cyc(1'b0, 4'd0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b1);
      for (int i = 0; i < 16; i++) ev(i, 1'b0);
      ev(16, 1'b1);
      chk("t4_count", {59'd0, fifo_count}, 64'd16);
      chk("t4_ovf",   {63'd0, overflow}, 64'd0);
      chk("t4_head",  {48'd0, trace_seq}, 64'd1);
      ev(17, 1'b0);
      chk("t4_drop_ovf", {63'd0, overflow}, 64'd1);
      for (int i = 0; i < 11; i++) idle(1'b1);
      chk("t4_left",  {59'd0, fifo_count}, 64'd5);
      chk("t4_head2", {48'd0, trace_seq}, 64'd12);

      // clr together with an event: flush wins and the event is not counted
      cyc(1'b1, 4'hF, 5'd3, 32'h0000_2000, 32'h5555_5555, 1'b0, 1'b1);
      chk("t5_valid", {63'd0, trace_valid}, 64'd0);
      chk("t5_count", {59'd0, fifo_count}, 64'd0);
      chk("t5_ovf",   {63'd0, overflow}, 64'd0);
      cyc(1'b1, 4'hF, 5'd4, 32'h0000_2004, 32'h6666_6666, 1'b0, 1'b0);
      chk("t5_seq",   {48'd0, trace_seq}, 64'd0);

      // Asynchronous reset mid-drain with 8 entries queued
      for (int i = 1; i < 10; i++) ev(i, 1'b0);
      idle(1'b1);
      idle(1'b1);
      chk("t6_count", {59'd0, fifo_count}, 64'd8);
      trace_ready = 1'b1;
      #2;
      resetn = 1'b0;
      model_clear();
      #1;
      chk("t6_valid", {63'd0, trace_valid}, 64'd0);
      chk("t6_cnt0",  {59'd0, fifo_count}, 64'd0);
      chk("t6_pc",    {32'd0, trace_pc}, 64'd0);
      chk("t6_seq",   {48'd0, trace_seq}, 64'd0);
      @(negedge clk);
      resetn = 1'b1;
      idle(1'b1);
      cyc(1'b1, 4'hF, 5'd9, 32'h0000_3000, 32'h7777_7777, 1'b0, 1'b0);
      chk("t6_seq_after", {48'd0, trace_seq}, 64'd0);
      idle(1'b1);
      idle(1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
